// File: rtl/mfcc_pkg.sv
// Shared types and default sizing for the MFCC frame sequencer.
// Default widths here match the top-level parameter defaults.
package mfcc_pkg;

  localparam int DEF_NUM_MEL    = 8;
  localparam int DEF_NUM_CEPS   = 4;
  localparam int DEF_DATA_WIDTH = 16;

  // A single-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MEL_PTR_W  = ptr_width(DEF_NUM_MEL);
  localparam int CEPS_PTR_W = ptr_width(DEF_NUM_CEPS);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_OUT
  } seq_state_t;

endpackage

// File: rtl/mel_frame_buf.sv
// Mel energy register file: one synchronous write port, one combinational read port.
module mel_frame_buf
  import mfcc_pkg::*;
#(
  parameter int NUM_MEL    = DEF_NUM_MEL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = ptr_width(NUM_MEL)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_MEL];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// Buffers one frame of mel energies and replays it once per cepstral coefficient into the log/DCT datapath.
// Define MFCC_SEQ_SKIP_C0_EN to iterate coefficients 1..NUM_CEPS-1 and never issue c0.
module mfcc_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int NUM_MEL    = DEF_NUM_MEL,
  parameter int NUM_CEPS   = DEF_NUM_CEPS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       mel_in,
  input  logic                        mel_valid,
  output logic                        mel_ready,
  output logic [DATA_WIDTH-1:0]       dp_data,
  output logic                        dp_valid,
  output logic                        dp_last,
  output logic [$clog2(NUM_CEPS)-1:0] dp_ceps,
  input  logic [DATA_WIDTH-1:0]       dp_result,
  input  logic                        dp_result_valid,
  output logic [DATA_WIDTH-1:0]       mfcc_out,
  output logic [$clog2(NUM_CEPS)-1:0] mfcc_idx,
  output logic                        mfcc_valid,
  input  logic                        mfcc_ready,
  output logic                        frame_done,
  output logic                        err_unexp
);

  localparam int CEPS_W = $clog2(NUM_CEPS);
  localparam int PTR_W  = ptr_width(NUM_MEL);
  localparam logic [PTR_W-1:0]  LAST_MEL  = PTR_W'(NUM_MEL - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CEPS_W-1:0] LAST_CEPS = CEPS_W'(NUM_CEPS - 1);
  localparam logic [CEPS_W-1:0] CEPS_ONE  = CEPS_W'(1);
`ifdef MFCC_SEQ_SKIP_C0_EN
  localparam logic [CEPS_W-1:0] CEPS_FIRST = CEPS_W'(1);
`else
  localparam logic [CEPS_W-1:0] CEPS_FIRST = '0;
`endif

  seq_state_t            r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, w_rd_addr;
  logic [CEPS_W-1:0]     r_ceps, r_mfcc_idx;
  logic [DATA_WIDTH-1:0] r_dp_data, r_mfcc_out, w_rd_data;
  logic                  r_mfcc_valid, r_frame_done, r_err_unexp;
  logic                  w_wr_en, w_bypass;

  assign w_wr_en  = (r_state == ST_LOAD) && mel_valid;
  assign w_bypass = w_wr_en && (r_wr_ptr == w_rd_addr);

  mel_frame_buf #(
    .NUM_MEL    (NUM_MEL),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PTR_W)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (mel_in),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mel_ready   = 1'b0;
    dp_valid    = 1'b0;
    dp_last     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        mel_ready = 1'b1;
        if (mel_valid && (r_wr_ptr == LAST_MEL)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        dp_valid = 1'b1;
        dp_last  = (r_rd_ptr == LAST_MEL);
        if (r_rd_ptr == LAST_MEL) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (dp_result_valid) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (mfcc_ready) w_state_nxt = (r_ceps == LAST_CEPS) ? ST_LOAD : ST_RUN;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // dp_data is registered, so the read address runs one beat ahead and parks on entry 0 outside RUN.
  always_comb begin
    w_rd_addr = '0;
    if ((r_state == ST_RUN) && (r_rd_ptr != LAST_MEL)) w_rd_addr = r_rd_ptr + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ceps       <= '0;
      r_dp_data    <= '0;
      r_mfcc_out   <= '0;
      r_mfcc_idx   <= '0;
      r_mfcc_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_unexp  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_dp_data    <= w_bypass ? mel_in : w_rd_data;
      if (dp_result_valid && (r_state != ST_WAIT)) r_err_unexp <= 1'b1;
      case (r_state)
        ST_LOAD: begin
          if (mel_valid) begin
            if (r_wr_ptr == LAST_MEL) begin
              r_wr_ptr <= '0;
              r_ceps   <= CEPS_FIRST;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
          end
        end
        ST_RUN: r_rd_ptr <= (r_rd_ptr == LAST_MEL) ? '0 : r_rd_ptr + PTR_ONE;
        ST_WAIT: begin
          if (dp_result_valid) begin
            r_mfcc_out   <= dp_result;
            r_mfcc_idx   <= r_ceps;
            r_mfcc_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (mfcc_ready) begin
            r_mfcc_valid <= 1'b0;
            if (r_ceps == LAST_CEPS) r_frame_done <= 1'b1;
            else                     r_ceps       <= r_ceps + CEPS_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign dp_data    = r_dp_data;
  assign dp_ceps    = r_ceps;
  assign mfcc_out   = r_mfcc_out;
  assign mfcc_idx   = r_mfcc_idx;
  assign mfcc_valid = r_mfcc_valid;
  assign frame_done = r_frame_done;
  assign err_unexp  = r_err_unexp;

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Self-checking bench for mfcc_frame_sequencer: table of frame vectors plus reset/error corner sequences.
// Expected coefficient results go through a scoreboard queue; honours MFCC_SEQ_SKIP_C0_EN.
module tb_mfcc_frame_sequencer;

  localparam int NMEL  = 8;
  localparam int NCEPS = 4;
`ifdef MFCC_SEQ_SKIP_C0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NOUT = NCEPS - FIRST;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mel_in;
  logic        mel_valid;
  logic        mel_ready;
  logic [15:0] dp_data;
  logic        dp_valid;
  logic        dp_last;
  logic [1:0]  dp_ceps;
  logic [15:0] dp_result;
  logic        dp_result_valid;
  logic [15:0] mfcc_out;
  logic [1:0]  mfcc_idx;
  logic        mfcc_valid;
  logic        mfcc_ready;
  logic        frame_done;
  logic        err_unexp;

  always #5 clk = ~clk;

  mfcc_frame_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .mel_in          (mel_in),
    .mel_valid       (mel_valid),
    .mel_ready       (mel_ready),
    .dp_data         (dp_data),
    .dp_valid        (dp_valid),
    .dp_last         (dp_last),
    .dp_ceps         (dp_ceps),
    .dp_result       (dp_result),
    .dp_result_valid (dp_result_valid),
    .mfcc_out        (mfcc_out),
    .mfcc_idx        (mfcc_idx),
    .mfcc_valid      (mfcc_valid),
    .mfcc_ready      (mfcc_ready),
    .frame_done      (frame_done),
    .err_unexp       (err_unexp)
  );

  typedef struct {
    logic [15:0] mel0;
    logic [15:0] melStep;
    logic [15:0] resBase;
    int          dpLat;
    int          readyDelay;
    int          errBeat;
    bit          collide;
    bit          preReset;
    int          expOutputs;
    int          expDone;
  } vec_t;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] data;
  } res_t;

  vec_t        vecs[4];
  res_t        sbQ[$];
  logic [15:0] frameMel[NMEL];
  int          nChecks = 0;
  int          nFails  = 0;
  int          hsSeen;
  int          doneSeen;
  logic        expErr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_mel_ready", mel_ready, 1);
    checkOutput("rst_dp_valid", dp_valid, 0);
    checkOutput("rst_dp_last", dp_last, 0);
    checkOutput("rst_dp_data", dp_data, 0);
    checkOutput("rst_dp_ceps", dp_ceps, 0);
    checkOutput("rst_mfcc_out", mfcc_out, 0);
    checkOutput("rst_mfcc_idx", mfcc_idx, 0);
    checkOutput("rst_mfcc_valid", mfcc_valid, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_err_unexp", err_unexp, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    checkResetState();
    @(negedge clk);
    rst    = 1'b0;
    expErr = 1'b0;
    tick();
    checkOutput("post_rst_mel_ready", mel_ready, 1);
  endtask

  // One idle cycle in the middle of the load checks that mel_valid gates the write.
  task automatic loadFrame(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < NMEL; i++) begin
      if (i == 4) begin
        mel_valid = 1'b0;
        tick();
      end
      checkOutput("load_mel_ready", mel_ready, 1);
      mel_in      = base + step * 16'(i);
      frameMel[i] = mel_in;
      mel_valid   = 1'b1;
      tick();
    end
    mel_valid = 1'b0;
    mel_in    = '0;
  endtask

  task automatic runPass(input int c, input int errBeat);
    for (int b = 0; b < NMEL; b++) begin
      checkOutput("dp_valid", dp_valid, 1);
      checkOutput("dp_data", dp_data, frameMel[b]);
      checkOutput("dp_ceps", dp_ceps, 32'(c));
      checkOutput("dp_last", dp_last, 32'(b == NMEL - 1));
      checkOutput("mel_ready_busy", mel_ready, 0);
      if (b == errBeat) begin
        dp_result       = 16'hBEEF;
        dp_result_valid = 1'b1;
        expErr          = 1'b1;
      end
      tick();
      dp_result_valid = 1'b0;
      dp_result       = '0;
    end
    checkOutput("dp_valid_wait", dp_valid, 0);
    checkOutput("err_unexp_run", err_unexp, expErr);
  endtask

  task automatic serveCoef(input int c, input logic [15:0] resVal, input int dpLat,
                           input int readyDelay, input bit collide);
    res_t expRes;
    int   w;
    for (int k = 0; k < dpLat; k++) begin
      checkOutput("wait_idle", {mfcc_valid, dp_valid}, 0);
      tick();
    end
    dp_result       = resVal;
    dp_result_valid = 1'b1;
    sbQ.push_back('{idx: 2'(c), data: resVal});
    tick();
    dp_result_valid = 1'b0;
    dp_result       = '0;
    w = 0;
    while (mfcc_valid !== 1'b1 && w < 16) begin
      tick();
      w++;
    end
    checkOutput("mfcc_valid_up", mfcc_valid, 1);
    expRes = '{idx: 2'(0), data: 16'h0};
    if (sbQ.size() != 0) expRes = sbQ.pop_front();
    for (int k = 0; k <= readyDelay; k++) begin
      checkOutput("mfcc_out", mfcc_out, expRes.data);
      checkOutput("mfcc_idx", mfcc_idx, expRes.idx);
      checkOutput("mfcc_valid_hold", mfcc_valid, 1);
      if (k < readyDelay) tick();
    end
    if (mfcc_valid === 1'b1) hsSeen++;
    mfcc_ready = 1'b1;
    if (collide) begin
      dp_result       = 16'hDEAD;
      dp_result_valid = 1'b1;
      expErr          = 1'b1;
    end
    tick();
    mfcc_ready      = 1'b0;
    dp_result_valid = 1'b0;
    dp_result       = '0;
    checkOutput("valid_cleared", mfcc_valid, 0);
    checkOutput("frame_done", frame_done, 32'(c == NCEPS - 1));
    if (frame_done === 1'b1) doneSeen++;
    checkOutput("err_unexp", err_unexp, expErr);
  endtask

  task automatic applyStimulus(input vec_t v);
    hsSeen   = 0;
    doneSeen = 0;
    loadFrame(v.mel0, v.melStep);
    for (int c = FIRST; c < NCEPS; c++) begin
      runPass(c, (c == FIRST) ? v.errBeat : -1);
      serveCoef(c, v.resBase + 16'(c), v.dpLat, v.readyDelay, v.collide && (c == FIRST));
    end
    tick();
    checkOutput("frame_done_one_cycle", frame_done, 0);
    checkOutput("mel_ready_idle", mel_ready, 1);
    checkOutput("handshakes", hsSeen, v.expOutputs);
    checkOutput("frame_done_count", doneSeen, v.expDone);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mel_in          = '0;
    mel_valid       = 1'b0;
    dp_result       = '0;
    dp_result_valid = 1'b0;
    mfcc_ready      = 1'b0;
    expErr          = 1'b0;
    rst             = 1'b0;

    vecs[0] = '{mel0: 16'h0010, melStep: 16'h0010, resBase: 16'h1234, dpLat: 2, readyDelay: 5,
                errBeat: -1, collide: 1'b0, preReset: 1'b0, expOutputs: NOUT, expDone: 1};
    vecs[1] = '{mel0: 16'h0100, melStep: 16'h0003, resBase: 16'h2000, dpLat: 0, readyDelay: 0,
                errBeat: -1, collide: 1'b0, preReset: 1'b0, expOutputs: NOUT, expDone: 1};
    vecs[2] = '{mel0: 16'h5555, melStep: 16'h1111, resBase: 16'h7FFF, dpLat: 1, readyDelay: 2,
                errBeat: -1, collide: 1'b1, preReset: 1'b0, expOutputs: NOUT, expDone: 1};
    vecs[3] = '{mel0: 16'hFFF0, melStep: 16'h0001, resBase: 16'h0A00, dpLat: 3, readyDelay: 1,
                errBeat: 3, collide: 1'b0, preReset: 1'b1, expOutputs: NOUT, expDone: 1};

    $display("[TB] reset");
    doReset();

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].preReset) doReset();
      $display("[TB] frame vector %0d", v);
      applyStimulus(vecs[v]);
    end

    // Reset while waiting on coefficient 2 must abandon the frame.
    $display("[TB] mid-frame reset");
    hsSeen   = 0;
    doneSeen = 0;
    loadFrame(16'h0010, 16'h0010);
    for (int c = FIRST; c <= 2; c++) begin
      runPass(c, -1);
      if (c < 2) serveCoef(c, 16'h3000 + 16'(c), 1, 0, 1'b0);
    end
    checkOutput("pre_rst_wait_valid", mfcc_valid, 0);
    doReset();
    for (int k = 0; k < 6; k++) begin
      checkOutput("abandon_mfcc_valid", mfcc_valid, 0);
      checkOutput("abandon_frame_done", frame_done, 0);
      checkOutput("abandon_mel_ready", mel_ready, 1);
      tick();
    end
    $display("[TB] frame after reset");
    applyStimulus(vecs[1]);

    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
